// File: rtl/can_tx_bitstuffer.sv
// rtl/can_tx_bitstuffer.sv - CAN bit timer, stuff-bit inserter and bus readback checker
module can_tx_bitstuffer #(
  parameter int BIT_CLKS  = 5000,
  parameter int SAMPLE_PT = 4000,
  parameter int STUFF_LEN = 5,
  parameter int CNT_W     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic in_bit,
  input  logic in_valid,
  output logic in_ready,
  input  logic stuff_en,
  input  logic arb_en,
  input  logic rx,
  output logic tx,
  output logic busy,
  output logic stuff_ins,
  output logic bit_err,
  output logic arb_lost
);

  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(SAMPLE_PT);
  localparam logic [3:0]       STUFF_RUN  = 4'(STUFF_LEN);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       run, run_nxt, run_inc;
  logic             last, last_nxt;
  logic             stuff_pend, stuff_pend_nxt;
  logic             tx_nxt, stuff_ins_nxt, bit_err_nxt, arb_lost_nxt;
  logic             launch_slot, sample_hit, arb_lost_cond, stuff_go, handshake;

  // A new bit may start when idle or on the final cycle of the current bit.
  assign launch_slot   = (state == IDLE) || ((state == ACTIVE) && (cnt == LAST_CNT));
  assign sample_hit    = (state == ACTIVE) && (cnt == SAMPLE_CNT);
  assign arb_lost_cond = sample_hit && arb_en && tx && !rx;
  // A pending stuff bit only counts while stuffing is still enabled; otherwise it is dropped.
  assign stuff_go      = launch_slot && stuff_pend && stuff_en;
  assign in_ready      = rst && launch_slot && !(stuff_pend && stuff_en) && !arb_lost_cond;
  assign handshake     = in_valid && in_ready;
  assign busy          = (state == ACTIVE);
  assign run_inc       = (run == STUFF_RUN) ? run : run + 4'd1;

  // Next-state logic: arbitration abort, then stuff bit, then data bit, then fall back to idle.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    tx_nxt         = tx;
    run_nxt        = run;
    last_nxt       = last;
    stuff_pend_nxt = stuff_pend;
    stuff_ins_nxt  = 1'b0;
    bit_err_nxt    = sample_hit && (rx != tx);
    arb_lost_nxt   = arb_lost_cond;

    if (state == ACTIVE) begin
      cnt_nxt = cnt + 1'b1;
    end

    if (arb_lost_cond) begin
      state_nxt      = IDLE;
      tx_nxt         = 1'b1;
      cnt_nxt        = '0;
      run_nxt        = 4'd0;
      stuff_pend_nxt = 1'b0;
    end else if (launch_slot) begin
      if (stuff_go) begin
        tx_nxt         = ~last;
        last_nxt       = ~last;
        run_nxt        = 4'd1;
        stuff_pend_nxt = 1'b0;
        stuff_ins_nxt  = 1'b1;
        cnt_nxt        = '0;
        state_nxt      = ACTIVE;
      end else if (handshake) begin
        tx_nxt    = in_bit;
        cnt_nxt   = '0;
        state_nxt = ACTIVE;
        last_nxt  = in_bit;
        if (stuff_en) begin
          run_nxt        = (in_bit == last) ? run_inc : 4'd1;
          stuff_pend_nxt = (run_nxt == STUFF_RUN);
        end else begin
          run_nxt        = 4'd0;
          stuff_pend_nxt = 1'b0;
        end
      end else begin
        stuff_pend_nxt = 1'b0;
        if (state == ACTIVE) begin
          state_nxt = IDLE;
          tx_nxt    = 1'b1;
          cnt_nxt   = '0;
          run_nxt   = 4'd0;
          last_nxt  = 1'b1;
        end
      end
    end
  end

  // State register; reset drives the bus recessive immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      tx         <= 1'b1;
      run        <= 4'd0;
      last       <= 1'b1;
      stuff_pend <= 1'b0;
      stuff_ins  <= 1'b0;
      bit_err    <= 1'b0;
      arb_lost   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      tx         <= tx_nxt;
      run        <= run_nxt;
      last       <= last_nxt;
      stuff_pend <= stuff_pend_nxt;
      stuff_ins  <= stuff_ins_nxt;
      bit_err    <= bit_err_nxt;
      arb_lost   <= arb_lost_nxt;
    end
  end

endmodule

// File: tb/tb_can_tx_bitstuffer.sv
// tb/tb_can_tx_bitstuffer.sv - directed bench for can_tx_bitstuffer
module tb_can_tx_bitstuffer;

  logic clk;
  logic rst;
  logic in_bit, in_valid, in_ready, stuff_en, arb_en, rx;
  logic tx, busy, stuff_ins, bit_err, arb_lost;
  logic rx_force, rx_val;

  int n_cmp = 0;
  int n_err = 0;

  logic src_bits [0:15];
  int   src_n, src_idx;
  logic exp_bits [0:15];
  int   exp_n;

  logic tx_tr [0:127];
  logic ir_tr [0:127];
  logic si_tr [0:127];
  logic be_tr [0:127];
  logic al_tr [0:127];
  logic bz_tr [0:127];

  assign rx = rx_force ? rx_val : tx;

  can_tx_bitstuffer #(
    .BIT_CLKS (8),
    .SAMPLE_PT(6),
    .STUFF_LEN(5),
    .CNT_W    (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_bit   (in_bit),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .stuff_en (stuff_en),
    .arb_en   (arb_en),
    .rx       (rx),
    .tx       (tx),
    .busy     (busy),
    .stuff_ins(stuff_ins),
    .bit_err  (bit_err),
    .arb_lost (arb_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic load_src(input int n, input logic [15:0] v);
    for (int i = 0; i < n; i++) src_bits[i] = v[n-1-i];
    src_n   = n;
    src_idx = 0;
  endtask

  task automatic set_exp(input int n, input logic [15:0] v);
    for (int i = 0; i < n; i++) exp_bits[i] = v[n-1-i];
    exp_n = n;
  endtask

  function automatic logic exp_tx(input int c);
    if (c == 0) return 1'b1;
    if ((c - 1) / 8 < exp_n) return exp_bits[(c - 1) / 8];
    return 1'b1;
  endfunction

  task automatic run_cycles(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      tx_tr[c] = tx;
      ir_tr[c] = in_ready;
      si_tr[c] = stuff_ins;
      be_tr[c] = bit_err;
      al_tr[c] = arb_lost;
      bz_tr[c] = busy;
      if (in_valid && ir_tr[c]) src_idx++;
      if (src_idx < src_n) begin
        in_valid = 1'b1;
        in_bit   = src_bits[src_idx];
      end else begin
        in_valid = 1'b0;
        in_bit   = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++; if (tx !== 1'b1)       begin n_err++; $display("FAIL rst_tx got %b exp 1", tx); end
    n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    n_cmp++; if ({stuff_ins, bit_err, arb_lost} !== 3'b000)
      begin n_err++; $display("FAIL rst_pulses got %b exp 000", {stuff_ins, bit_err, arb_lost}); end
    rst = 1'b1;
    load_src(1, 16'b0);
    rx_force = 1'b1;
    rx_val   = 1'b1;
    run_cycles(9);
    n_cmp++; if (tx_tr[8] !== 1'b0) begin n_err++; $display("FAIL rst_pre_tx got %b exp 0", tx_tr[8]); end
    n_cmp++; if (be_tr[8] !== 1'b1) begin n_err++; $display("FAIL rst_pre_bit_err got %b exp 1", be_tr[8]); end
    rst = 1'b0;
    #1;
    n_cmp++; if (tx !== 1'b1)       begin n_err++; $display("FAIL rst_mid_tx got %b exp 1", tx); end
    n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
    n_cmp++; if (bit_err !== 1'b0)  begin n_err++; $display("FAIL rst_mid_bit_err got %b exp 0", bit_err); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_mid_in_ready got %b exp 0", in_ready); end
    n_cmp++; if ({stuff_ins, arb_lost} !== 2'b00)
      begin n_err++; $display("FAIL rst_mid_pulses got %b exp 00", {stuff_ins, arb_lost}); end
    repeat (2) @(negedge clk);
    rx_force = 1'b0;
    rst = 1'b1;
    run_cycles(12);
    for (int c = 0; c < 12; c++) begin
      n_cmp++; if (tx_tr[c] !== 1'b1) begin n_err++; $display("FAIL rst_idle_tx cyc %0d got %b exp 1", c, tx_tr[c]); end
      n_cmp++; if (bz_tr[c] !== 1'b0) begin n_err++; $display("FAIL rst_idle_busy cyc %0d got %b exp 0", c, bz_tr[c]); end
      n_cmp++; if (ir_tr[c] !== 1'b1) begin n_err++; $display("FAIL rst_idle_ready cyc %0d got %b exp 1", c, ir_tr[c]); end
    end
  endtask

  task automatic test_stuffing;
    int cnt_si;
    stuff_en = 1'b1;
    load_src(6, 16'b000000);
    set_exp(7, 16'b0000010);
    run_cycles(60);
    cnt_si = 0;
    for (int c = 0; c < 60; c++) begin
      n_cmp++; if (tx_tr[c] !== exp_tx(c))
        begin n_err++; $display("FAIL stuff_tx cyc %0d got %b exp %b", c, tx_tr[c], exp_tx(c)); end
      if (si_tr[c] === 1'b1) cnt_si++;
    end
    n_cmp++; if (cnt_si != 1)       begin n_err++; $display("FAIL stuff_count got %0d exp 1", cnt_si); end
    n_cmp++; if (si_tr[41] !== 1'b1) begin n_err++; $display("FAIL stuff_pulse_pos got %b exp 1", si_tr[41]); end
    n_cmp++; if (ir_tr[40] !== 1'b0) begin n_err++; $display("FAIL stuff_slot_ready got %b exp 0", ir_tr[40]); end
    n_cmp++; if (ir_tr[48] !== 1'b1) begin n_err++; $display("FAIL post_stuff_ready got %b exp 1", ir_tr[48]); end
    n_cmp++; if (src_idx != 6)      begin n_err++; $display("FAIL stuff_consumed got %0d exp 6", src_idx); end
  endtask

  task automatic test_stuff_disabled;
    int cnt_si;
    stuff_en = 1'b0;
    load_src(7, 16'b1111111);
    set_exp(7, 16'b1111111);
    run_cycles(60);
    cnt_si = 0;
    for (int c = 0; c < 60; c++) begin
      n_cmp++; if (tx_tr[c] !== exp_tx(c))
        begin n_err++; $display("FAIL nostuff_tx cyc %0d got %b exp %b", c, tx_tr[c], exp_tx(c)); end
      if (si_tr[c] === 1'b1) cnt_si++;
    end
    n_cmp++; if (cnt_si != 0)        begin n_err++; $display("FAIL nostuff_count got %0d exp 0", cnt_si); end
    n_cmp++; if (bz_tr[56] !== 1'b1) begin n_err++; $display("FAIL nostuff_busy_last got %b exp 1", bz_tr[56]); end
    n_cmp++; if (bz_tr[57] !== 1'b0) begin n_err++; $display("FAIL nostuff_idle got %b exp 0", bz_tr[57]); end
  endtask

  task automatic test_mixed_run;
    int cnt_si;
    stuff_en = 1'b1;
    load_src(10, 16'b1111000001);
    set_exp(11, 16'b11110000011);
    run_cycles(92);
    cnt_si = 0;
    for (int c = 0; c < 92; c++) begin
      n_cmp++; if (tx_tr[c] !== exp_tx(c))
        begin n_err++; $display("FAIL mixed_tx cyc %0d got %b exp %b", c, tx_tr[c], exp_tx(c)); end
      if (si_tr[c] === 1'b1) cnt_si++;
    end
    n_cmp++; if (cnt_si != 1)        begin n_err++; $display("FAIL mixed_count got %0d exp 1", cnt_si); end
    n_cmp++; if (si_tr[73] !== 1'b1) begin n_err++; $display("FAIL mixed_pulse_pos got %b exp 1", si_tr[73]); end
    n_cmp++; if (bz_tr[89] !== 1'b0) begin n_err++; $display("FAIL mixed_idle got %b exp 0", bz_tr[89]); end
    stuff_en = 1'b0;
  endtask

  task automatic test_arb_loss;
    int cnt_al;
    arb_en   = 1'b1;
    rx_force = 1'b1;
    rx_val   = 1'b0;
    load_src(1, 16'b1);
    run_cycles(12);
    cnt_al = 0;
    for (int c = 0; c < 12; c++) if (al_tr[c] === 1'b1) cnt_al++;
    n_cmp++; if (bz_tr[7] !== 1'b1)  begin n_err++; $display("FAIL arb_busy_before got %b exp 1", bz_tr[7]); end
    n_cmp++; if (ir_tr[7] !== 1'b0)  begin n_err++; $display("FAIL arb_ready_before got %b exp 0", ir_tr[7]); end
    n_cmp++; if (be_tr[7] !== 1'b0)  begin n_err++; $display("FAIL arb_bit_err_early got %b exp 0", be_tr[7]); end
    n_cmp++; if (al_tr[8] !== 1'b1)  begin n_err++; $display("FAIL arb_lost_pulse got %b exp 1", al_tr[8]); end
    n_cmp++; if (be_tr[8] !== 1'b1)  begin n_err++; $display("FAIL arb_bit_err_pulse got %b exp 1", be_tr[8]); end
    n_cmp++; if (tx_tr[8] !== 1'b1)  begin n_err++; $display("FAIL arb_tx_after got %b exp 1", tx_tr[8]); end
    n_cmp++; if (bz_tr[8] !== 1'b0)  begin n_err++; $display("FAIL arb_busy_after got %b exp 0", bz_tr[8]); end
    n_cmp++; if (ir_tr[8] !== 1'b1)  begin n_err++; $display("FAIL arb_ready_idle got %b exp 1", ir_tr[8]); end
    n_cmp++; if (cnt_al != 1)        begin n_err++; $display("FAIL arb_lost_count got %0d exp 1", cnt_al); end
    rx_force = 1'b0;
    arb_en   = 1'b0;
  endtask

  task automatic test_bit_err;
    int cnt_be, cnt_al;
    rx_force = 1'b1;
    rx_val   = 1'b1;
    load_src(1, 16'b0);
    set_exp(1, 16'b0);
    run_cycles(12);
    cnt_be = 0;
    cnt_al = 0;
    for (int c = 0; c < 12; c++) begin
      n_cmp++; if (tx_tr[c] !== exp_tx(c))
        begin n_err++; $display("FAIL berr_tx cyc %0d got %b exp %b", c, tx_tr[c], exp_tx(c)); end
      if (be_tr[c] === 1'b1) cnt_be++;
      if (al_tr[c] === 1'b1) cnt_al++;
    end
    n_cmp++; if (be_tr[8] !== 1'b1)  begin n_err++; $display("FAIL berr_pulse_pos got %b exp 1", be_tr[8]); end
    n_cmp++; if (cnt_be != 1)        begin n_err++; $display("FAIL berr_count got %0d exp 1", cnt_be); end
    n_cmp++; if (cnt_al != 0)        begin n_err++; $display("FAIL berr_arb_lost got %0d exp 0", cnt_al); end
    n_cmp++; if (bz_tr[8] !== 1'b1)  begin n_err++; $display("FAIL berr_busy_full got %b exp 1", bz_tr[8]); end
    n_cmp++; if (bz_tr[9] !== 1'b0)  begin n_err++; $display("FAIL berr_idle got %b exp 0", bz_tr[9]); end
    rx_force = 1'b0;
  endtask

  initial begin
    rst      = 1'b0;
    in_bit   = 1'b0;
    in_valid = 1'b0;
    stuff_en = 1'b0;
    arb_en   = 1'b0;
    rx_force = 1'b0;
    rx_val   = 1'b1;
    src_n    = 0;
    src_idx  = 0;
    exp_n    = 0;
    test_reset;
    test_stuffing;
    test_stuff_disabled;
    test_mixed_run;
    test_arb_loss;
    test_bit_err;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/can_tx_bitstuffer.md
Name: can_tx_bitstuffer

Overview:
- Parametrised serial CAN bit transmitter that sits between the frame serializer (`can_tx` family) and the bus pin.
- Times each bit from `clk` using a programmable bit length and inserts CAN stuff bits after STUFF_LEN identical bits.
- Reads the bus back at a programmable sample point and reports bit errors and arbitration loss.
- Replaces the fixed 4000/5000-count bit-inversion container.

Parameters:
- BIT_CLKS, default 5000: `clk` cycles per bit time; legal range 4..2^CNT_W-1.
- SAMPLE_PT, default 4000: cycle offset within the bit at which `rx` is sampled; legal range 1..BIT_CLKS-2.
- STUFF_LEN, default 5: run of identical bits after which a complement bit is inserted; legal range 2..15.
- CNT_W, default 16: width of the bit-time counter.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- in_bit, input, 1: next unstuffed frame bit (1 = recessive).
- in_valid, input, 1: `in_bit` is presented.
- in_ready, output, 1: block accepts `in_bit` this cycle.
- stuff_en, input, 1: stuffing enabled (high from SOF through CRC).
- arb_en, input, 1: arbitration field active.
- rx, input, 1: bus readback.
- tx, output, 1: bus drive, registered.
- busy, output, 1: a bit is being driven.
- stuff_ins, output, 1: one-cycle pulse when a stuff bit is launched.
- bit_err, output, 1: one-cycle pulse on readback mismatch.
- arb_lost, output, 1: one-cycle pulse on arbitration loss.

Behaviour:
- Reset values while `rst` is low: tx=1, busy=0, in_ready=0, stuff_ins=0, bit_err=0, arb_lost=0. Internally: state=IDLE, cnt=0, run=0, last=1, stuff_pend=0.
- States:
  - IDLE: tx=1, cnt held at 0.
  - ACTIVE: cnt increments each cycle, 0..BIT_CLKS-1.
- Launch slot (combinational): (IDLE) or (ACTIVE and cnt==BIT_CLKS-1).
- in_ready = launch slot and !stuff_pend and !arb_lost_cond. A handshake is in_valid and in_ready.
- At a launch slot, in priority order; for all three cases the new tx is visible the cycle after the slot:
  1. stuff_pend: tx<=~last, last<=~last, run<=1, stuff_pend<=0, stuff_ins pulses, cnt<=0, state ACTIVE. `in_bit` is not consumed.
  2. Handshake: tx<=in_bit, cnt<=0, state ACTIVE.
     - If stuff_en: run<=(in_bit==last)?run+1:1.
     - last<=in_bit.
     - If the new run==STUFF_LEN and stuff_en: stuff_pend<=1.
  3. Otherwise, if ACTIVE with no valid input: state<=IDLE, tx<=1, run<=0, last<=1.
- stuff_en low at a handshake: run<=0 and stuff_pend<=0. A stuff bit already pending when stuff_en drops is discarded.
- A stuff bit is still emitted after the final data bit if pending; the block returns to IDLE afterwards.
- run saturates; it never exceeds STUFF_LEN, because a stuff bit always resets it.
- Sample point is ACTIVE and cnt==SAMPLE_PT:
  - rx!=tx: bit_err pulses the next cycle.
  - Additionally arb_en and tx==1 and rx==0: arb_lost pulses. On the same cycle state<=IDLE, tx<=1, cnt<=0, run<=0, stuff_pend<=0, and the remainder of the current bit is abandoned. bit_err also pulses in this case.
- busy = (state==ACTIVE).
- Reset asserted mid-bit: immediate return to reset values, tx recessive. No partial bit is completed after reset release.
- in_valid may drop or in_bit may change between launch slots without effect. Only the value at the handshake cycle is used.

Test Plan (BIT_CLKS=8, SAMPLE_PT=6, STUFF_LEN=5, rx=tx unless stated):
1. Reset: rst low mid-bit while driving 0 -> tx=1, busy=0 and all pulses 0 within the same cycle. After release, IDLE with tx=1 until in_valid.
2. Stuffing: stuff_en=1, feed 0,0,0,0,0,0 back-to-back -> tx shows five 0 bits of 8 cycles each, then one 1 bit with stuff_ins pulsing once, then the sixth 0. in_ready is low during the stuff slot.
3. Stuff disabled: stuff_en=0, feed seven 1s -> tx is 1 for 56 cycles, stuff_ins never pulses, then IDLE.
4. Mixed run: stuff_en=1, feed 1,1,1,1,0,0,0,0,0,1 -> no stuff after the four 1s; a 1 is inserted after the fifth 0. Exactly one stuff_ins pulse across 11 bit times.
5. Arbitration loss: arb_en=1, drive in_bit=1 while rx forced 0 -> bit_err and arb_lost pulse one cycle after cnt==6; tx=1 and busy=0 the following cycle; in_ready waits for IDLE.
6. Bit error without arbitration: arb_en=0, in_bit=0 with rx forced 1 -> bit_err pulses, arb_lost stays 0, and the bit completes its full 8 cycles.
